// File: rtl/data_memory_responder.sv
// Valid/ready data-memory responder for the MEM-stage load/store port.
// Fixed-latency byte/half/word accesses with load extension and error flagging.
module data_memory_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we,
   input  logic [2:0]  req_ctrl,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic          we_q;
   logic [2:0]    ctrl_q;

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic          do_access;
   logic          bad_access;
   logic [31:0]   rd_word;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_data;
   logic [3:0]    wr_mask;
   logic [31:0]   wr_data;
   logic          unused_addr_bits;

   // Upper address bits select nothing: storage wraps modulo DEPTH words.
   assign unused_addr_bits = &{1'b0, req_addr[31:AW+2]};

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign idx       = addr_q[AW+1:2];
   assign lane      = addr_q[1:0];
   assign do_access = (state == WAIT) && (cnt == '0);
   assign rd_word   = mem[idx];
   assign ld_byte   = rd_word[{lane, 3'b000} +: 8];
   assign ld_half   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      bad_access = 1'b0;
      ld_data    = '0;
      wr_mask    = 4'b1111;
      wr_data    = wdata_q;
      case (ctrl_q)
         3'b000, 3'b100: bad_access = 1'b0;
         3'b001, 3'b101: bad_access = addr_q[0];
         3'b010:         bad_access = (lane != 2'b00);
         default:        bad_access = 1'b1;
      endcase
      if (we_q && ctrl_q[2])
         bad_access = 1'b1;
      case (ctrl_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = rd_word;
      endcase
      case (ctrl_q[1:0])
         2'b00: begin
            wr_mask = 4'b0001 << lane;
            wr_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            wr_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata_q[15:0]}};
         end
         default: begin
            wr_mask = 4'b1111;
            wr_data = wdata_q;
         end
      endcase
   end

   // NOTE: storage has no reset; only the control path is cleared, which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (do_access && we_q && !bad_access && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_mask[i])
               mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         ctrl_q   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr[AW+1:0];
                  wdata_q <= req_wdata;
                  we_q    <= req_we;
                  ctrl_q  <= req_ctrl;
                  cnt     <= CW'(LATENCY - 1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_err  <= bad_access;
                  rsp_data <= (bad_access || we_q) ? 32'h0 : ld_data;
                  state    <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: byte-array reference model feeds
// a scoreboard of expected responses, checked when the responder answers.
module tb_data_memory_responder;

   localparam int DEPTH   = 256;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_we = 1'b0;
   logic [2:0]  req_ctrl = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mdl [DEPTH*4];
   int         total = 0;
   int         bad   = 0;

   data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_we    (req_we),
      .req_ctrl  (req_ctrl),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model on a flat byte array, little-endian lanes.
   function automatic exp_t model_access(input logic [31:0] a, input logic [31:0] wd,
                                         input logic we, input logic [2:0] c);
      exp_t        r;
      int unsigned ba;
      int unsigned wb;
      logic        err;
      ba  = a & (DEPTH*4 - 1);
      wb  = ba & ~32'd3;
      err = (c == 3'b011) || (c == 3'b110) || (c == 3'b111) || (we && c[2]) ||
            (c[1:0] == 2'b01 && a[0]) || (c[1:0] == 2'b10 && a[1:0] != 2'b00);
      r.err  = err;
      r.data = '0;
      if (!err && we) begin
         case (c[1:0])
            2'b00: mdl[ba] = wd[7:0];
            2'b01: begin
               mdl[ba]   = wd[7:0];
               mdl[ba+1] = wd[15:8];
            end
            default: begin
               mdl[wb]   = wd[7:0];
               mdl[wb+1] = wd[15:8];
               mdl[wb+2] = wd[23:16];
               mdl[wb+3] = wd[31:24];
            end
         endcase
      end else if (!err) begin
         case (c)
            3'b000:  r.data = {{24{mdl[ba][7]}}, mdl[ba]};
            3'b100:  r.data = {24'h0, mdl[ba]};
            3'b001:  r.data = {{16{mdl[ba+1][7]}}, mdl[ba+1], mdl[ba]};
            3'b101:  r.data = {16'h0, mdl[ba+1], mdl[ba]};
            default: r.data = {mdl[wb+3], mdl[wb+2], mdl[wb+1], mdl[wb]};
         endcase
      end
      return r;
   endfunction

   task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [2:0] c, input int hold);
      exp_t e;
      int   lat;
      sb.push_back(model_access(a, wd, we, c));
      @(negedge clk);
      req_addr  = a;
      req_wdata = wd;
      req_we    = we;
      req_ctrl  = c;
      req_valid = 1'b1;
      check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, " ready_wait"}, 32'(req_ready), 32'd0);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, " latency"}, 32'(lat), 32'(LATENCY));
      if (sb.size() == 0) begin
         check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, " data"}, rsp_data, e.data);
         check({tag, " err"}, 32'(rsp_err), 32'(e.err));
         for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold_data"}, rsp_data, e.data);
            check({tag, " hold_ready"}, 32'(req_ready), 32'd0);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, " done_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, " done_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      #1;
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_data", rsp_data, 32'd0);
      check("reset rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      access("sw_10",  32'h10, 32'hDEADBEEF, 1'b1, 3'b010, 0);
      access("lw_10",  32'h10, 32'h0,        1'b0, 3'b010, 0);
      access("sb_13",  32'h13, 32'h00000080, 1'b1, 3'b000, 0);
      access("lb_13",  32'h13, 32'h0,        1'b0, 3'b000, 0);
      access("lbu_13", 32'h13, 32'h0,        1'b0, 3'b100, 0);
      access("lw_10b", 32'h10, 32'h0,        1'b0, 3'b010, 0);
      access("sh_16",  32'h16, 32'h00008001, 1'b1, 3'b001, 0);
      access("lh_16",  32'h16, 32'h0,        1'b0, 3'b001, 0);
      access("lhu_16", 32'h16, 32'h0,        1'b0, 3'b101, 0);
      access("lh_11",  32'h11, 32'h0,        1'b0, 3'b001, 0);
      access("sw_mis", 32'h12, 32'hFFFFFFFF, 1'b1, 3'b010, 0);
      access("sbu_il", 32'h14, 32'hFFFFFFFF, 1'b1, 3'b100, 0);
      access("lw_14",  32'h14, 32'h0,        1'b0, 3'b010, 0);
      access("lw_hold", 32'h10, 32'h0,       1'b0, 3'b010, 3);

      // A store caught in WAIT by reset must never reach storage.
      access("sw_20",  32'h20, 32'h0BADF00D, 1'b1, 3'b010, 0);
      @(negedge clk);
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      req_we    = 1'b1;
      req_ctrl  = 3'b010;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_mid ready_wait", 32'(req_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_mid req_ready", 32'(req_ready), 32'd1);
      check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid rsp_data", rsp_data, 32'd0);
      check("rst_mid rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      access("lw_20",  32'h20, 32'h0,        1'b0, 3'b010, 0);

      access("sw_400", 32'h400, 32'hA5A5A5A5, 1'b1, 3'b010, 0);
      access("lw_0",   32'h0,   32'h0,        1'b0, 3'b010, 0);
      access("ctrl011", 32'h0,  32'h0,        1'b0, 3'b011, 0);
      access("ctrl111", 32'h8,  32'h0,        1'b0, 3'b111, 0);
      access("lbu_402", 32'h402, 32'h0,       1'b0, 3'b100, 0);

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
